// File: rtl/c2f_drain.sv
// Drains full chunks from the C2F burst RAM onto a 64-bit valid/ready stream
// and hands each chunk back to tlp_xcvr once its last word has been consumed.
module c2f_drain #(
    parameter int CI_BITS = 2,
    parameter int CO_BITS = 4
) (
    input  logic                       clk_in,
    input  logic                       rstn_in,
    input  logic [CI_BITS-1:0]         c2fWrPtr_in,
    output logic [CI_BITS-1:0]         c2fRdPtr_out,
    output logic                       c2fDTAck_out,
    output logic [CI_BITS+CO_BITS-1:0] ramAddr_out,
    input  logic [63:0]                ramData_in,
    output logic [63:0]                data_out,
    output logic                       valid_out,
    input  logic                       ready_in,
    output logic                       last_out
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CI_BITS-1:0] rd_ptr;
    logic               ack;
    logic               inflight;
    logic               inflight_last;
    logic [63:0]        fifo_data [4];
    logic [3:0]         fifo_last;
    logic [1:0]         wr_idx;
    logic [1:0]         rd_idx;
    logic [2:0]         count;
    logic               credit;
    logic               issue;
    logic               issue_last;
    logic               start;
    logic               push;
    logic               pop;
    logic               last_pop;

    assign push         = inflight;
    assign valid_out    = (count != 3'd0);
    assign pop          = valid_out & ready_in;
    assign data_out     = fifo_data[rd_idx];
    assign last_out     = valid_out & fifo_last[rd_idx];
    assign last_pop     = pop & fifo_last[rd_idx];
    assign c2fRdPtr_out = rd_ptr;
    assign c2fDTAck_out = ack;

    // Counting the in-flight read guarantees its push always finds room.
    assign credit = (({1'b0, count} + 4'(inflight)) < 4'd4);

    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        issue      = 1'b0;
        issue_last = 1'b0;
        start      = 1'b0;
        case (state)
            IDLE: begin
                if (c2fWrPtr_in != rd_ptr) begin
                    state_nxt = READ;
                    start     = 1'b1;
                end
            end
            READ: begin
                if (credit) begin
                    issue = 1'b1;
                    if (ramAddr_out[CO_BITS-1:0] == '1) begin
                        issue_last = 1'b1;
                        state_nxt  = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (last_pop) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The low address bits double as the chunk offset; the address is held outside READ.
    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            ramAddr_out   <= '0;
            rd_ptr        <= '0;
            ack           <= 1'b0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight      <= issue;
            inflight_last <= issue_last;
            ack           <= (state == DRAIN) & last_pop;
            if (start) begin
                ramAddr_out <= {rd_ptr, {CO_BITS{1'b0}}};
            end else if (issue && !issue_last) begin
                ramAddr_out <= ramAddr_out + 1'b1;
            end
            if ((state == DRAIN) && last_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            for (int i = 0; i < 4; i++) begin
                fifo_data[i] <= '0;
            end
            fifo_last <= '0;
            wr_idx    <= '0;
            rd_idx    <= '0;
            count     <= '0;
        end else begin
            if (push) begin
                fifo_data[wr_idx] <= ramData_in;
                fifo_last[wr_idx] <= inflight_last;
                wr_idx            <= wr_idx + 2'd1;
            end
            if (pop) begin
                rd_idx <= rd_idx + 2'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_c2f_drain.sv
// Directed bench for c2f_drain: a registered-read RAM model filled with a known
// pattern feeds the DUT, and each scenario task checks its own expected words and timing.
module tb_c2f_drain;

    logic        clk_in = 1'b0;
    logic        rstn_in = 1'b0;
    logic [1:0]  c2fWrPtr_in = 2'd0;
    logic [1:0]  c2fRdPtr_out;
    logic        c2fDTAck_out;
    logic [5:0]  ramAddr_out;
    logic [63:0] ramData_in = 64'd0;
    logic [63:0] data_out;
    logic        valid_out;
    logic        ready_in = 1'b0;
    logic        last_out;

    logic [63:0] ram [64];
    int          vectors = 0;
    int          miscompares = 0;

    c2f_drain #(.CI_BITS(2), .CO_BITS(4)) dut (
        .clk_in       (clk_in),
        .rstn_in      (rstn_in),
        .c2fWrPtr_in  (c2fWrPtr_in),
        .c2fRdPtr_out (c2fRdPtr_out),
        .c2fDTAck_out (c2fDTAck_out),
        .ramAddr_out  (ramAddr_out),
        .ramData_in   (ramData_in),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .ready_in     (ready_in),
        .last_out     (last_out)
    );

    always #5 clk_in = ~clk_in;

    // Registered read with exactly one cycle of latency.
    always @(posedge clk_in) ramData_in <= ram[ramAddr_out];

    function automatic logic [63:0] seq64(input int a);
        return {32'hC2F0_0000 + 32'(a), 32'hA5A5_0000 ^ 32'(a)};
    endfunction

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic apply_reset();
        c2fWrPtr_in = 2'd0;
        ready_in    = 1'b1;
        rstn_in     = 1'b0;
        step();
        step();
        rstn_in = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rstn_in     = 1'b0;
        c2fWrPtr_in = 2'd0;
        ready_in    = 1'b0;
        step();
        step();
        vectors++;
        if (c2fRdPtr_out !== 2'd0) begin
            miscompares++; $display("[TB] FAIL reset_rdptr got %h want 0", c2fRdPtr_out);
        end
        vectors++;
        if (c2fDTAck_out !== 1'b0) begin
            miscompares++; $display("[TB] FAIL reset_ack got %b want 0", c2fDTAck_out);
        end
        vectors++;
        if (ramAddr_out !== 6'd0) begin
            miscompares++; $display("[TB] FAIL reset_addr got %h want 0", ramAddr_out);
        end
        vectors++;
        if (data_out !== 64'd0) begin
            miscompares++; $display("[TB] FAIL reset_data got %h want 0", data_out);
        end
        vectors++;
        if (valid_out !== 1'b0) begin
            miscompares++; $display("[TB] FAIL reset_valid got %b want 0", valid_out);
        end
        vectors++;
        if (last_out !== 1'b0) begin
            miscompares++; $display("[TB] FAIL reset_last got %b want 0", last_out);
        end
        rstn_in = 1'b1;
        step();
        step();
        vectors++;
        if ({valid_out, c2fDTAck_out, ramAddr_out} !== 8'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_release got v=%b ack=%b addr=%h want 0/0/0",
                     valid_out, c2fDTAck_out, ramAddr_out);
        end
    endtask

    task automatic test_single_chunk();
        ready_in    = 1'b1;
        c2fWrPtr_in = 2'd1;
        step();
        vectors++;
        if ({valid_out, ramAddr_out} !== {1'b0, 6'd0}) begin
            miscompares++;
            $display("[TB] FAIL single_n1 got v=%b addr=%h want 0/00", valid_out, ramAddr_out);
        end
        step();
        vectors++;
        if ({valid_out, ramAddr_out} !== {1'b0, 6'd1}) begin
            miscompares++;
            $display("[TB] FAIL single_n2 got v=%b addr=%h want 0/01", valid_out, ramAddr_out);
        end
        step();
        for (int i = 0; i < 16; i++) begin
            vectors++;
            if ({valid_out, last_out, c2fDTAck_out, data_out} !== {1'b1, (i == 15), 1'b0, seq64(i)}) begin
                miscompares++;
                $display("[TB] FAIL single_word%0d got v=%b l=%b ack=%b d=%h want 1/%b/0/%h",
                         i, valid_out, last_out, c2fDTAck_out, data_out, (i == 15), seq64(i));
            end
            step();
        end
        vectors++;
        if ({c2fDTAck_out, c2fRdPtr_out, valid_out} !== {1'b1, 2'd1, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL single_release got ack=%b rd=%0d v=%b want 1/1/0",
                     c2fDTAck_out, c2fRdPtr_out, valid_out);
        end
        step();
        vectors++;
        if ({c2fDTAck_out, valid_out} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL single_ack_pulse got ack=%b v=%b want 0/0", c2fDTAck_out, valid_out);
        end
    endtask

    task automatic test_empty_hold();
        c2fWrPtr_in = 2'd1;
        for (int c = 0; c < 100; c++) begin
            vectors++;
            if ({valid_out, c2fDTAck_out, ramAddr_out} !== {1'b0, 1'b0, 6'd15}) begin
                miscompares++;
                $display("[TB] FAIL empty_hold c=%0d got v=%b ack=%b addr=%h want 0/0/0f",
                         c, valid_out, c2fDTAck_out, ramAddr_out);
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        int          k = 0;
        int          acks = 0;
        int          chunk;
        int          off;
        logic        stalled = 1'b0;
        logic [65:0] held = '0;
        c2fWrPtr_in = 2'd0;
        for (int cyc = 0; cyc < 1000 && acks < 3; cyc++) begin
            if (stalled) begin
                vectors++;
                if ({valid_out, last_out, data_out} !== held) begin
                    miscompares++;
                    $display("[TB] FAIL bp_stall_hold k=%0d got %h want %h",
                             k, {valid_out, last_out, data_out}, held);
                end
            end
            if (c2fDTAck_out) acks++;
            ready_in = 1'($urandom_range(0, 1));
            if (valid_out && ready_in) begin
                chunk = 1 + k / 16;
                off   = k % 16;
                vectors++;
                if (k >= 48) begin
                    miscompares++;
                    $display("[TB] FAIL bp_extra_word got %h want none", data_out);
                end else if ({last_out, data_out} !== {(off == 15), seq64(chunk * 16 + off)}) begin
                    miscompares++;
                    $display("[TB] FAIL bp_word k=%0d got l=%b d=%h want l=%b d=%h",
                             k, last_out, data_out, (off == 15), seq64(chunk * 16 + off));
                end
                k++;
            end
            stalled = valid_out && !ready_in;
            held    = {valid_out, last_out, data_out};
            step();
        end
        ready_in = 1'b1;
        vectors++;
        if (k != 48 || acks != 3 || c2fRdPtr_out !== 2'd0 || valid_out !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bp_totals got words=%0d acks=%0d rd=%0d v=%b want 48/3/0/0",
                     k, acks, c2fRdPtr_out, valid_out);
        end
    endtask

    task automatic test_wrap();
        int   k;
        logic got_ack;
        apply_reset();
        for (int ch = 0; ch < 5; ch++) begin
            c2fWrPtr_in = 2'(ch + 1);
            k       = 0;
            got_ack = 1'b0;
            for (int cyc = 0; cyc < 60 && !got_ack; cyc++) begin
                if (valid_out) begin
                    vectors++;
                    if ({last_out, data_out} !== {(k == 15), seq64((ch % 4) * 16 + k)}) begin
                        miscompares++;
                        $display("[TB] FAIL wrap_word ch=%0d k=%0d got l=%b d=%h want l=%b d=%h",
                                 ch, k, last_out, data_out, (k == 15), seq64((ch % 4) * 16 + k));
                    end
                    k++;
                end
                if (c2fDTAck_out) begin
                    got_ack = 1'b1;
                    vectors++;
                    if (c2fRdPtr_out !== 2'((ch + 1) % 4) || k != 16) begin
                        miscompares++;
                        $display("[TB] FAIL wrap_release ch=%0d got rd=%0d words=%0d want %0d/16",
                                 ch, c2fRdPtr_out, k, (ch + 1) % 4);
                    end
                end
                step();
            end
            if (!got_ack) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL wrap_timeout ch=%0d got no ack want ack", ch);
            end
        end
    endtask

    task automatic test_back_to_back();
        int          j;
        int          pos;
        logic        ev;
        logic        el;
        logic        ea;
        logic [1:0]  er;
        logic [63:0] ed;
        apply_reset();
        c2fWrPtr_in = 2'd3;
        for (int c = 1; c <= 64; c++) begin
            step();
            j   = (c >= 3) ? (c - 3) / 19 : 0;
            pos = (c >= 3) ? (c - 3) % 19 : 99;
            ev  = (c >= 3) && (j < 3) && (pos <= 15);
            el  = ev && (pos == 15);
            ed  = ev ? seq64(j * 16 + pos) : 64'd0;
            ea  = (c == 19) || (c == 38) || (c == 57);
            er  = (c < 19) ? 2'd0 : (c < 38) ? 2'd1 : (c < 57) ? 2'd2 : 2'd3;
            vectors++;
            if ({valid_out, last_out, c2fDTAck_out, c2fRdPtr_out} !== {ev, el, ea, er} ||
                (ev && data_out !== ed)) begin
                miscompares++;
                $display("[TB] FAIL b2b c=%0d got v=%b l=%b ack=%b rd=%0d d=%h want v=%b l=%b ack=%b rd=%0d d=%h",
                         c, valid_out, last_out, c2fDTAck_out, c2fRdPtr_out, data_out,
                         ev, el, ea, er, ed);
            end
        end
    endtask

    task automatic test_reset_mid_chunk();
        int   pops = 0;
        int   k = 0;
        logic got_ack = 1'b0;
        apply_reset();
        c2fWrPtr_in = 2'd1;
        for (int cyc = 0; cyc < 40 && pops < 7; cyc++) begin
            if (valid_out) pops++;
            step();
        end
        #2;
        rstn_in = 1'b0;
        #1;
        vectors++;
        if ({c2fRdPtr_out, c2fDTAck_out, ramAddr_out, data_out, valid_out, last_out} !== 74'd0 || pops != 7) begin
            miscompares++;
            $display("[TB] FAIL midreset_async got rd=%0d ack=%b addr=%h d=%h v=%b l=%b pops=%0d want all 0, 7 pops",
                     c2fRdPtr_out, c2fDTAck_out, ramAddr_out, data_out, valid_out, last_out, pops);
        end
        step();
        step();
        rstn_in = 1'b1;
        for (int c = 1; c <= 40 && !got_ack; c++) begin
            step();
            if (valid_out) begin
                if (k == 0) begin
                    vectors++;
                    if (c != 3) begin
                        miscompares++;
                        $display("[TB] FAIL midreset_latency got %0d want 3", c);
                    end
                end
                vectors++;
                if ({last_out, data_out} !== {(k == 15), seq64(k)}) begin
                    miscompares++;
                    $display("[TB] FAIL midreset_word k=%0d got l=%b d=%h want l=%b d=%h",
                             k, last_out, data_out, (k == 15), seq64(k));
                end
                k++;
            end
            if (c2fDTAck_out) begin
                got_ack = 1'b1;
                vectors++;
                if (c2fRdPtr_out !== 2'd1 || k != 16) begin
                    miscompares++;
                    $display("[TB] FAIL midreset_release got rd=%0d words=%0d want 1/16", c2fRdPtr_out, k);
                end
            end
        end
        if (!got_ack) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL midreset_timeout got no ack want ack");
        end
    endtask

    initial begin
        for (int a = 0; a < 64; a++) ram[a] = seq64(a);
        test_reset();
        test_single_chunk();
        test_empty_hold();
        test_backpressure();
        test_wrap();
        test_back_to_back();
        test_reset_mid_chunk();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
